// File: rtl/sixteen_bit_divider.sv
// sixteen_bit_divider: multi-cycle 16-bit restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module sixteen_bit_divider (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [15:0] rem_reg, rem_next;
    logic [15:0] quo_reg, quo_next;
    logic [15:0] dsr_reg, dsr_next;
    logic [15:0] raw_reg, raw_next;
    logic        neg_quo_reg, neg_quo_next;
    logic        neg_rem_reg, neg_rem_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [15:0] q_out_reg, q_out_next;
    logic [15:0] r_out_reg, r_out_next;
    logic        dz_reg, dz_next;

    logic        dividend_neg;
    logic        divisor_neg;
    logic [15:0] mag_dividend;
    logic [15:0] mag_divisor;
    logic [17:0] trial;
    logic        borrow;
    logic [15:0] fix_quo;
    logic [15:0] fix_rem;

    // In the unsigned build the sign bits are forced low, so magnitudes and
    // correction collapse to pass-through.
    assign dividend_neg = SIGNED_MODE & dividend[15];
    assign divisor_neg  = SIGNED_MODE & divisor[15];
    assign mag_dividend = dividend_neg ? (16'd0 - dividend) : dividend;
    assign mag_divisor  = divisor_neg  ? (16'd0 - divisor)  : divisor;

    // Trial subtraction of {partial remainder, next dividend bit}; bit 17 is the borrow.
    assign trial  = {1'b0, rem_reg, quo_reg[15]} - {2'b00, dsr_reg};
    assign borrow = trial[17];

    assign fix_quo = neg_quo_reg ? (16'd0 - quo_reg) : quo_reg;
    assign fix_rem = neg_rem_reg ? (16'd0 - rem_reg) : rem_reg;

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        dsr_next     = dsr_reg;
        raw_next     = raw_reg;
        neg_quo_next = neg_quo_reg;
        neg_rem_next = neg_rem_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        q_out_next   = q_out_reg;
        r_out_next   = r_out_reg;
        dz_next      = dz_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    raw_next  = dividend;
                    busy_next = 1'b1;
                    if (divisor == 16'd0) begin
                        state_next = DZ;
                    end else begin
                        rem_next     = 16'd0;
                        quo_next     = mag_dividend;
                        dsr_next     = mag_divisor;
                        neg_quo_next = dividend_neg ^ divisor_neg;
                        neg_rem_next = dividend_neg;
                        count_next   = 4'd0;
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                // On borrow the shifted remainder is below the divisor, so its MSB is 0.
                rem_next = borrow ? {rem_reg[14:0], quo_reg[15]} : trial[15:0];
                quo_next = {quo_reg[14:0], ~borrow};
                if (count_reg == 4'd15) begin
                    count_next = 4'd0;
                    state_next = FIX;
                end else begin
                    count_next = count_reg + 4'd1;
                end
            end
            FIX: begin
                q_out_next = fix_quo;
                r_out_next = fix_rem;
                dz_next    = 1'b0;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            DZ: begin
                q_out_next = 16'hFFFF;
                r_out_next = raw_reg;
                dz_next    = 1'b1;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= 4'd0;
            rem_reg     <= 16'd0;
            quo_reg     <= 16'd0;
            dsr_reg     <= 16'd0;
            raw_reg     <= 16'd0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            q_out_reg   <= 16'd0;
            r_out_reg   <= 16'd0;
            dz_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            dsr_reg     <= dsr_next;
            raw_reg     <= raw_next;
            neg_quo_reg <= neg_quo_next;
            neg_rem_reg <= neg_rem_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            q_out_reg   <= q_out_next;
            r_out_reg   <= r_out_next;
            dz_reg      <= dz_next;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = q_out_reg;
    assign remainder   = r_out_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_sixteen_bit_divider.sv
// Testbench for sixteen_bit_divider: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed results (both builds handled via DIVIDER_SIGNED_EN).
module tb_sixteen_bit_divider;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sixteen_bit_divider dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference arithmetic: plain integer division in the selected number system.
    function automatic void model_div(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] q, output logic [15:0] r,
                                      output logic dz);
        int qi;
        int ri;
        if (b == 16'd0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            qi = int'($signed(a)) / int'($signed(b));
            ri = int'($signed(a)) % int'($signed(b));
`else
            qi = int'(a) / int'(b);
            ri = int'(a) % int'(b);
`endif
            q  = qi[15:0];
            r  = ri[15:0];
            dz = 1'b0;
        end
    endfunction

    // Timing model: an accepted request occupies the unit for a fixed number of edges.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_q = 16'd0;
    logic [15:0] m_r = 16'd0;
    logic        m_dz = 1'b0;
    logic [15:0] p_q = 16'd0;
    logic [15:0] p_r = 16'd0;
    logic        p_dz = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = 16'd0;
            m_r    = 16'd0;
            m_dz   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dz   = p_dz;
                end
            end else if (start) begin
                model_div(dividend, divisor, p_q, p_r, p_dz);
                m_left = p_dz ? 1 : 17;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("cyc_done", {31'd0, done}, {31'd0, m_done});
        check("cyc_quotient", {16'd0, quotient}, {16'd0, m_q});
        check("cyc_remainder", {16'd0, remainder}, {16'd0, m_r});
        check("cyc_dz", {31'd0, div_by_zero}, {31'd0, m_dz});
        if (done === 1'b1)
            $display("txn t=%0t quotient=%h remainder=%h div_by_zero=%b", $time, quotient, remainder, div_by_zero);
    end

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done expected=done_within_%0d", limit);
        end
    endtask

    task automatic check_results(input string name, input logic [15:0] eq, input logic [15:0] er, input logic edz);
        check({name, "_q"}, {16'd0, quotient}, {16'd0, eq});
        check({name, "_r"}, {16'd0, remainder}, {16'd0, er});
        check({name, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input int elat, input logic [15:0] eq, input logic [15:0] er, input logic edz);
        int lat;
        launch(a, b);
        wait_done(40, lat);
        check({name, "_latency"}, lat, elat);
        check_results(name, eq, er, edz);
    endtask

    task automatic run_plain(input logic [15:0] a, input logic [15:0] b);
        int lat;
        launch(a, b);
        wait_done(40, lat);
    endtask

    initial begin
        int lat;
        logic [15:0] tbl_a [7];
        logic [15:0] tbl_b [7];
        tbl_a = '{16'd12345, 16'd7, 16'd0, 16'd65535, 16'd1, 16'h8001, 16'd40000};
        tbl_b = '{16'd123, 16'hFFFE, 16'd5, 16'd65535, 16'd1, 16'd3, 16'hFF00};

        repeat (3) @(posedge clk);
        #1;
        check_results("reset", 16'd0, 16'd0, 1'b0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;

        run_op("d1000_7", 16'd1000, 16'd7, 18, 16'h008E, 16'd6, 1'b0);

        // Abort in the middle of RUN; everything must clear at once.
        launch(16'd1000, 16'd7);
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_results("midreset", 16'd0, 16'd0, 1'b0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_op("d100_10", 16'd100, 16'd10, 18, 16'd10, 16'd0, 1'b0);

        run_op("d5_0", 16'd5, 16'd0, 2, 16'hFFFF, 16'd5, 1'b1);
        run_op("d100_10b", 16'd100, 16'd10, 18, 16'd10, 16'd0, 1'b0);

        // Start during iteration 3 is ignored; start in the done cycle is accepted.
        launch(16'd1000, 16'd7);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 16'd9;
        divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, lat);
        check("ignored_latency", lat, 14);
        check_results("ignored", 16'h008E, 16'd6, 1'b0);
        start = 1'b1;
        dividend = 16'd9;
        divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, lat);
        check("donecycle_latency", lat, 18);
        check_results("donecycle", 16'd3, 16'd0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
        run_op("dfff9_2", 16'hFFF9, 16'd2, 18, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op("d8000_ffff", 16'h8000, 16'hFFFF, 18, 16'h8000, 16'd0, 1'b0);
        run_op("dffff_1", 16'hFFFF, 16'd1, 18, 16'hFFFF, 16'd0, 1'b0);
`else
        run_op("dfff9_2", 16'hFFF9, 16'd2, 18, 16'h7FFC, 16'd1, 1'b0);
        run_op("d8000_ffff", 16'h8000, 16'hFFFF, 18, 16'h0000, 16'h8000, 1'b0);
        run_op("dffff_1", 16'hFFFF, 16'd1, 18, 16'hFFFF, 16'd0, 1'b0);
`endif

        for (int i = 0; i < 7; i++)
            run_plain(tbl_a[i], tbl_b[i]);

        // Back-to-back requests with start held high.
        @(posedge clk); #1;
        start = 1'b1;
        dividend = 16'd200;
        divisor = 16'd3;
        repeat (40) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_results("b2b", 16'd66, 16'd2, 1'b0);
        check("b2b_idle", {31'd0, busy}, 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
